pulse_evt_logger: RTL and testbench

//  Slow-domain consumer of the 1-bit pulse CDC handshake output. Timestamps

---
 rtl/pulse_evt_logger.sv | 132 +++++++++++++
 tb/tb_pulse_evt_logger.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_evt_logger.sv
// pulse_evt_logger
// Slow-domain consumer of the pulse CDC handshake. Each event pulse is
// stamped with a free-running clk_s counter and queued in a small
// first-word-fall-through FIFO that is drained over a valid/ready port.
// Events arriving while the FIFO is full (and not being popped) are dropped
// and counted in a saturating counter, with a sticky overflow flag.
//
// Optional feature macro: PULSE_LOG_EDGE_EN
//   Defined   : evt_pulse goes through a rising-edge detector, so a level
//               held for several cycles produces a single event.
//   Undefined : every cycle with evt_pulse high is an event (default).

module pulse_evt_logger #(
   parameter int TS_W   = 16,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                       clk_s,
   input  logic                       rst_n,
   input  logic                       evt_pulse,
   input  logic                       clr,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [TS_W-1:0]            out_ts,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf,
   output logic [DROP_W-1:0]          drop_cnt
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [TS_W-1:0]   TS_ONE   = 1;
   localparam logic [AW:0]       PTR_ONE  = 1;
   localparam logic [DROP_W-1:0] DROP_ONE = 1;

   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;

   logic evt;
   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;

`ifdef PULSE_LOG_EDGE_EN
   logic evt_q;

   // Remember last cycle's pulse level so only a 0->1 transition counts
   always_ff @(posedge clk_s or negedge rst_n) begin
      if (!rst_n) begin
         evt_q <= 1'b0;
      end else begin
         evt_q <= evt_pulse;
      end
   end

   assign evt = evt_pulse & ~evt_q;
`else
   assign evt = evt_pulse;
`endif

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees a slot in the same cycle, so a push into a full FIFO that
   // is being popped still succeeds; clr overrides everything
   assign pop  = !clr && !empty && out_ready;
   assign push = !clr && evt && (!full || pop);
   assign drop = !clr && evt && full && !pop;

   assign out_valid = !empty;
   assign out_ts    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign level     = wr_ptr - rd_ptr;

   // Free-running timestamp, wraps silently, restarts from 0 on clr
   always_ff @(posedge clk_s or negedge rst_n) begin
      if (!rst_n) begin
         ts <= '0;
      end else if (clr) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_ONE;
      end
   end

   // Storage write; contents behind an empty FIFO are never visible
   always_ff @(posedge clk_s) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= ts;
      end
   end

   // Read and write pointers; clr empties the FIFO in one cycle
   always_ff @(posedge clk_s or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk_s or negedge rst_n) begin
      if (!rst_n) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (clr) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + DROP_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pulse_evt_logger.sv
// tb_pulse_evt_logger
// Self-checking bench for pulse_evt_logger. A queue-based reference model
// tracks the timestamp, FIFO contents, overflow flag and drop count.
// Honours PULSE_LOG_EDGE_EN the same way the design does.

module tb_pulse_evt_logger;

   localparam int TS_W   = 16;
   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;

   logic              clk_s;
   logic              rst_n;
   logic              evt_pulse;
   logic              clr;
   logic              out_ready;
   logic              out_valid;
   logic [TS_W-1:0]   out_ts;
   logic [2:0]        level;
   logic              ovf;
   logic [DROP_W-1:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [TS_W-1:0]   q[$];
   logic [TS_W-1:0]   m_ts;
   logic              m_ovf;
   logic [DROP_W-1:0] m_drop;
   logic              m_prev;

   pulse_evt_logger #(
      .TS_W  (TS_W),
      .DEPTH (DEPTH),
      .DROP_W(DROP_W)
   ) dut (
      .clk_s    (clk_s),
      .rst_n    (rst_n),
      .evt_pulse(evt_pulse),
      .clr      (clr),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_ts   (out_ts),
      .level    (level),
      .ovf      (ovf),
      .drop_cnt (drop_cnt)
   );

   initial clk_s = 1'b0;
   always #5 clk_s = ~clk_s;

   // Behavioural model: a queue of timestamps with the spec's push/pop/drop rules
   always @(posedge clk_s or negedge rst_n) begin
      logic ev;
      logic popv;
      logic was_full;
      if (!rst_n) begin
         q.delete();
         m_ts   = '0;
         m_ovf  = 1'b0;
         m_drop = '0;
         m_prev = 1'b0;
      end else begin
`ifdef PULSE_LOG_EDGE_EN
         ev = evt_pulse && !m_prev;
`else
         ev = evt_pulse;
`endif
         m_prev = evt_pulse;
         if (clr) begin
            q.delete();
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = '0;
         end else begin
            popv     = (q.size() != 0) && out_ready;
            was_full = (q.size() == DEPTH);
            if (popv) void'(q.pop_front());
            if (ev) begin
               if (was_full && !popv) begin
                  m_ovf = 1'b1;
                  if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
               end else begin
                  q.push_back(m_ts);
               end
            end
            m_ts = m_ts + 16'd1;
         end
      end
   end

   function automatic logic [TS_W-1:0] exp_ts();
      return (q.size() != 0) ? q[0] : '0;
   endfunction

   task automatic drive(input logic e, input logic r, input logic c);
      evt_pulse = e;
      out_ready = r;
      clr       = c;
      @(posedge clk_s);
      #1;
   endtask

   task automatic wait_ts(input logic [TS_W-1:0] target, input logic r);
      int n;
      n = 0;
      while (m_ts != target && n < 70000) begin
         drive(1'b0, r, 1'b0);
         n++;
      end
      checks++;
      if (m_ts != target) begin
         errors++;
         $display("[TB] FAIL wait_ts: ts=%0h never reached target %0h", m_ts, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; evt_pulse = 1'b0; clr = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk_s);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
      checks++; if (out_ts !== 16'h0) begin errors++; $display("[TB] FAIL reset_ts: got %0h want 0", out_ts); end
      checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b want 0", ovf); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      wait_ts(16'd5, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b want 1", out_valid); end
      checks++; if (out_ts !== 16'd5) begin errors++; $display("[TB] FAIL single_ts: got %0d want 5", out_ts); end
      checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL single_level: got %0d want 1", level); end
      drive(1'b0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_drop: got %0b want 0", out_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL single_level_drop: got %0d want 0", level); end
   endtask

   task automatic test_overflow();
      logic [TS_W-1:0] want [4];
      want[0] = 16'd10; want[1] = 16'd20; want[2] = 16'd30; want[3] = 16'd40;
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         wait_ts(16'(i * 10), 1'b0);
         drive(1'b1, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level: got %0d want 4", level); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b want 1", ovf); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL ovf_drop: got %0d want 1", drop_cnt); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_ts !== want[i]) begin errors++; $display("[TB] FAIL ovf_drain%0d: got %0d want %0d", i, out_ts, want[i]); end
         drive(1'b0, 1'b1, 1'b0);
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty: got %0b want 0", out_valid); end
   endtask

   task automatic test_full_push_pop();
      logic [TS_W-1:0] second;
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 1'b0);
      end
      checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL fpp_prelevel: got %0d want 4", level); end
      second = 16'd2;
      drive(1'b1, 1'b1, 1'b0);
      checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL fpp_level: got %0d want 4", level); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL fpp_ovf: got %0b want 0", ovf); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL fpp_drop: got %0d want 0", drop_cnt); end
      checks++; if (out_ts !== second) begin errors++; $display("[TB] FAIL fpp_head: got %0d want %0d", out_ts, second); end
      checks++; if (out_ts !== exp_ts()) begin errors++; $display("[TB] FAIL fpp_model: got %0d want %0d", out_ts, exp_ts()); end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 1'b1);
      wait_ts(16'hFFFF, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (out_ts !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_first: got %0h want ffff", out_ts); end
`ifdef PULSE_LOG_EDGE_EN
      checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL wrap_level: got %0d want 1", level); end
`else
      checks++; if (level !== 3'd2) begin errors++; $display("[TB] FAIL wrap_level: got %0d want 2", level); end
      drive(1'b0, 1'b1, 1'b0);
      checks++; if (out_ts !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_second: got %0h want 0", out_ts); end
`endif
   endtask

   task automatic test_clr();
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0);
      checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL clr_prelevel: got %0d want 3", level); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL clr_preovf: got %0b want 1", ovf); end
      drive(1'b1, 1'b0, 1'b1);
      checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL clr_level: got %0d want 0", level); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_valid: got %0b want 0", out_valid); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf: got %0b want 0", ovf); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clr_drop: got %0d want 0", drop_cnt); end
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (out_ts !== 16'd1) begin errors++; $display("[TB] FAIL clr_ts_restart: got %0d want 1", out_ts); end
      checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL clr_post_level: got %0d want 1", level); end
   endtask

   task automatic test_held();
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
`ifdef PULSE_LOG_EDGE_EN
      checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL held_level: got %0d want 1", level); end
      checks++; if (out_ts !== 16'd0) begin errors++; $display("[TB] FAIL held_ts: got %0d want 0", out_ts); end
`else
      checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL held_level: got %0d want 3", level); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_ts !== 16'(i)) begin errors++; $display("[TB] FAIL held_entry%0d: got %0d want %0d", i, out_ts, i); end
         drive(1'b0, 1'b1, 1'b0);
      end
`endif
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 1'b0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %0b want 0", out_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL arst_level: got %0d want 0", level); end
      checks++; if (out_ts !== 16'd0) begin errors++; $display("[TB] FAIL arst_ts: got %0h want 0", out_ts); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL arst_ovf: got %0b want 0", ovf); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL arst_drop: got %0d want 0", drop_cnt); end
      @(posedge clk_s);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic e;
      logic r;
      logic c;
      for (int n = 0; n < 3000; n++) begin
         e = ($urandom_range(0, 2) != 0);
         r = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 199) == 0);
         drive(e, r, c);
         checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %0b want %0b", n, out_valid, q.size() != 0); end
         checks++; if (out_ts !== exp_ts()) begin errors++; $display("[TB] FAIL rnd_ts@%0d: got %0h want %0h", n, out_ts, exp_ts()); end
         checks++; if (level !== 3'(q.size())) begin errors++; $display("[TB] FAIL rnd_level@%0d: got %0d want %0d", n, level, q.size()); end
         checks++; if (ovf !== m_ovf) begin errors++; $display("[TB] FAIL rnd_ovf@%0d: got %0b want %0b", n, ovf, m_ovf); end
         checks++; if (drop_cnt !== m_drop) begin errors++; $display("[TB] FAIL rnd_drop@%0d: got %0d want %0d", n, drop_cnt, m_drop); end
      end
   endtask

   // Run the scenarios in sequence and report
   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_clr();
      test_held();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
